sram_bist: RTL and testbench

Parametrised SRAM built-in self-test engine for NORA. It is the synthesizable successor of the CPU-bus write/read-back checks. On a start pulse it writes a generated pattern over an address window. It then reads the window back and compares each word. It records error count, first failing address and data, and timeout or abort status. It acts as a bus master on the NORA internal memory request port, in parallel with the CPU path, and is arbitrated upstream.

---
 rtl/sram_bist_if.sv | 23 ++
 rtl/sram_bist.sv | 236 +++++++++++++++++++++++
 tb/tb_sram_bist.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_if.sv
// Memory request port between the BIST engine (master) and the upstream
// arbiter / SRAM (slave). Request fields are held until the one-cycle ack.
interface sram_bist_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/sram_bist.sv
// SRAM built-in self-test engine: writes a generated pattern over an address
// window, reads it back, and records mismatch / timeout / abort status.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; status from the previous run is held
// WR_REQ | write request on the bus, waiting for ack
// WR_GAP | one dead cycle after a write ack; picks next write or read phase
// RD_REQ | read request on the bus, compare on ack
// RD_GAP | one dead cycle after a read ack; picks next read or finish
// DONE   | one-cycle done pulse, then back to IDLE
module sram_bist #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  sram_bist_if.master       mem,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              timed_out,
  output logic              aborted,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  // latched run configuration
  logic [ADDR_W-1:0] base_q, len_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;

  // walking position: current address, words left in the phase, i mod DATA_W
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [BIT_W-1:0]  bit_q;

  // ack wait down-counter, terminal count 0 means the request timed out
  logic [TO_W-1:0]   wait_q;

  // registered bus request fields
  logic              req_q, we_q;
  logic [DATA_W-1:0] wdata_q;

  // decoded events for this cycle
  logic              in_req;
  logic              go_start, ack_hit, abort_hit, to_hit, phase_end;
  logic              mismatch;
  logic [DATA_W-1:0] exp_data;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [BIT_W-1:0]  b,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] walk;
    lo   = a[DATA_W-1:0];
    walk = DATA_W'(1) << b;
    case (m)
      2'd0:    return s;
      2'd1:    return lo ^ s;
      2'd2:    return walk ^ s;
      default: return ~(lo ^ s);
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode and per-cycle event strobes; abort beats ack and timeout
  always_comb begin
    state_nxt = state;
    go_start  = 1'b0;
    ack_hit   = 1'b0;
    abort_hit = 1'b0;
    to_hit    = 1'b0;
    phase_end = 1'b0;
    mismatch  = 1'b0;
    in_req    = (state == WR_REQ) || (state == RD_REQ);
    exp_data  = pattern(mode_q, seed_q, bit_q, addr_q);
    case (state)
      IDLE: begin
        if (start) begin
          go_start  = 1'b1;
          state_nxt = (cfg_len == '0) ? DONE : WR_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = DONE;
        end else if (mem.ack) begin
          ack_hit   = 1'b1;
          mismatch  = (state == RD_REQ) && (mem.rdata != exp_data);
          state_nxt = (state == WR_REQ) ? WR_GAP : RD_GAP;
        end else if (wait_q == '0) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      WR_GAP, RD_GAP: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = DONE;
        end else if (rem_q == '0) begin
          phase_end = 1'b1;
          state_nxt = (state == WR_GAP) ? RD_REQ : DONE;
        end else begin
          state_nxt = (state == WR_GAP) ? WR_REQ : RD_REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // configuration latch and address / word / bit walkers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      mode_q <= '0;
      seed_q <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      bit_q  <= '0;
    end else if (go_start) begin
      base_q <= cfg_base;
      len_q  <= cfg_len;
      mode_q <= cfg_mode;
      seed_q <= cfg_seed;
      addr_q <= cfg_base;
      rem_q  <= cfg_len;
      bit_q  <= '0;
    end else if (ack_hit) begin
      addr_q <= addr_q + ADDR_W'(1);
      rem_q  <= rem_q - ADDR_W'(1);
      bit_q  <= (bit_q == BIT_W'(DATA_W - 1)) ? '0 : bit_q + BIT_W'(1);
    end else if (phase_end && (state == WR_GAP)) begin
      addr_q <= base_q;
      rem_q  <= len_q;
      bit_q  <= '0;
    end
  end

  // ack wait counter: preloaded outside requests, counts down while requesting
  always_ff @(posedge clk) begin
    if (rst)         wait_q <= TO_W'(TIMEOUT - 1);
    else if (in_req) wait_q <= wait_q - TO_W'(1);
    else             wait_q <= TO_W'(TIMEOUT - 1);
  end

  // bus request fields, registered from the next state so they only move on
  // request boundaries; write data is refreshed in the gap before each write
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      req_q <= (state_nxt == WR_REQ) || (state_nxt == RD_REQ);
      we_q  <= (state_nxt == WR_REQ);
      if (go_start)
        wdata_q <= pattern(cfg_mode, cfg_seed, '0, cfg_base);
      else if (state == WR_GAP)
        wdata_q <= exp_data;
    end
  end

  // sticky run status, cleared by start; first mismatch captured once
  always_ff @(posedge clk) begin
    if (rst || go_start) begin
      fail      <= 1'b0;
      timed_out <= 1'b0;
      aborted   <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
      fail    <= 1'b1;
    end else if (to_hit) begin
      timed_out <= 1'b1;
      fail      <= 1'b1;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (err_count != '1)
        err_count <= err_count + CNT_W'(1);
      if (err_count == '0) begin
        fail_addr <= addr_q;
        fail_exp  <= exp_data;
        fail_got  <= mem.rdata;
      end
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  assign busy = (state == WR_REQ) || (state == WR_GAP) ||
                (state == RD_REQ) || (state == RD_GAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist: table of runs against an SRAM model with
// optional read corruption, plus timeout, abort, reset and random-wait runs.
module tb_sram_bist;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int TO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort;
  logic [AW-1:0] cfg_base, cfg_len;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic          busy, done, fail, timed_out, aborted;
  logic [CW-1:0] err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;

  sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bist #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .mem(bus),
    .busy(busy), .done(done), .fail(fail), .timed_out(timed_out), .aborted(aborted),
    .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
  );

  // SRAM model
  logic [DW-1:0]    mem_arr [0:(1<<AW)-1];
  bit               no_ack = 1'b0, rand_wait = 1'b0, force_en = 1'b0, force_all = 1'b0;
  logic [AW-1:0]    force_addr = '0;
  logic [DW-1:0]    force_val = '0;
  int               wcnt = 0, wtgt = 0;
  logic [AW+DW-1:0] wlog[$];

  always_comb begin
    bus.ack = bus.req && !no_ack && (wcnt == wtgt);
    if (force_all)                              bus.rdata = ~mem_arr[bus.addr];
    else if (force_en && bus.addr == force_addr) bus.rdata = force_val;
    else                                        bus.rdata = mem_arr[bus.addr];
  end

  always @(posedge clk) begin
    if (bus.req && bus.ack) begin
      if (bus.we) begin
        mem_arr[bus.addr] <= bus.wdata;
        wlog.push_back({bus.addr, bus.wdata});
      end
      wcnt <= 0;
      wtgt <= rand_wait ? int'($urandom_range(0, 7)) : 0;
    end else if (bus.req) wcnt <= wcnt + 1;
    else                  wcnt <= 0;
  end

  // request stability monitor and request-cycle counter
  bit            mon_en = 1'b0;
  int            stab_err = 0, req_cycles = 0;
  logic          p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(negedge clk) begin
    if (mon_en && p_req && !p_ack &&
        (!bus.req || bus.we !== p_we || bus.addr !== p_addr || bus.wdata !== p_wdata))
      stab_err++;
    if (bus.req) req_cycles++;
    p_req = bus.req; p_ack = bus.ack; p_we = bus.we; p_addr = bus.addr; p_wdata = bus.wdata;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pat(input logic [1:0] m, input logic [DW-1:0] s,
                                            input int i, input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    logic [DW-1:0] one;
    lo  = a[DW-1:0];
    one = 8'd1 << (i % DW);
    case (m)
      2'd0:    return s;
      2'd1:    return lo ^ s;
      2'd2:    return one ^ s;
      default: return ~(lo ^ s);
    endcase
  endfunction

  // start a run and wait (bounded) for done; cyc = cycles after the start edge
  task automatic run_bist(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [1:0] m, input logic [DW-1:0] s, output int cyc);
    @(negedge clk);
    cfg_base = b; cfg_len = l; cfg_mode = m; cfg_seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL run_done: no done within %0d cycles", cyc);
      cyc = -1;
    end
  endtask

  // count write-log entries since index ls that disagree with the expected pattern
  function automatic int bad_writes(input int ls, input logic [AW-1:0] b, input int l,
                                    input logic [1:0] m, input logic [DW-1:0] s);
    int nb;
    logic [AW-1:0] a;
    logic [AW+DW-1:0] e;
    nb = 0;
    if (wlog.size() - ls != l) nb++;
    for (int j = 0; j < l && ls + j < wlog.size(); j++) begin
      a = b + AW'(j);
      e = wlog[ls + j];
      if (e[AW+DW-1:DW] !== a || e[DW-1:0] !== exp_pat(m, s, j, a)) nb++;
    end
    return nb;
  endfunction

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    bit            fen;
    bit            fall;
    logic [AW-1:0] f_at;
    logic [DW-1:0] f_val;
    int            cyc;
    bit            e_fail;
    int            e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_exp;
    logic [DW-1:0] e_got;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc, ls, n, rq0, nd;
    logic [AW-1:0] rb;
    logic [DW-1:0] rs;

    vecs[0] = '{17'h00010, 17'd4,  2'd1, 8'h00, 1'b0, 1'b0, 17'h0,     8'h00, 17, 1'b0, 0, 17'h0,     8'h00, 8'h00};
    vecs[1] = '{17'h00010, 17'd4,  2'd0, 8'hA5, 1'b1, 1'b0, 17'h00012, 8'h5A, 17, 1'b1, 1, 17'h00012, 8'hA5, 8'h5A};
    vecs[2] = '{17'h1FFFE, 17'd4,  2'd3, 8'hFF, 1'b0, 1'b0, 17'h0,     8'h00, 17, 1'b0, 0, 17'h0,     8'h00, 8'h00};
    vecs[3] = '{17'h00300, 17'd0,  2'd1, 8'h12, 1'b0, 1'b0, 17'h0,     8'h00, 1,  1'b0, 0, 17'h0,     8'h00, 8'h00};
    vecs[4] = '{17'h00100, 17'd10, 2'd2, 8'h0F, 1'b1, 1'b0, 17'h00109, 8'h00, 41, 1'b1, 1, 17'h00109, 8'h0D, 8'h00};
    vecs[5] = '{17'h00200, 17'd5,  2'd1, 8'h00, 1'b0, 1'b1, 17'h0,     8'h00, 21, 1'b1, 3, 17'h00200, 8'h00, 8'hFF};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_base = '0; cfg_len = '0; cfg_mode = '0; cfg_seed = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fail", fail, 0);
    chk("reset err_count", err_count, 0);
    chk("reset req", bus.req, 0);
    chk("reset we_addr", {bus.we, bus.addr}, 0);
    rst = 1'b0;

    // table-driven runs with a zero-wait slave
    for (int k = 0; k < 6; k++) begin
      force_en = vecs[k].fen; force_all = vecs[k].fall;
      force_addr = vecs[k].f_at; force_val = vecs[k].f_val;
      ls = wlog.size();
      run_bist(vecs[k].base, vecs[k].len, vecs[k].mode, vecs[k].seed, cyc);
      chk($sformatf("v%0d done_cycle", k), cyc, vecs[k].cyc);
      chk($sformatf("v%0d busy_at_done", k), busy, 0);
      chk($sformatf("v%0d fail", k), fail, vecs[k].e_fail);
      chk($sformatf("v%0d err_count", k), err_count, vecs[k].e_err);
      chk($sformatf("v%0d fail_addr", k), fail_addr, vecs[k].e_addr);
      chk($sformatf("v%0d fail_exp", k), fail_exp, vecs[k].e_exp);
      chk($sformatf("v%0d fail_got", k), fail_got, vecs[k].e_got);
      chk($sformatf("v%0d timeout_abort", k), {timed_out, aborted}, 0);
      chk($sformatf("v%0d writes", k),
          bad_writes(ls, vecs[k].base, int'(vecs[k].len), vecs[k].mode, vecs[k].seed), 0);
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", k), done, 0);
      chk($sformatf("v%0d fail_held", k), fail, vecs[k].e_fail);
    end
    force_en = 1'b0; force_all = 1'b0;

    // slave never acks: 255 request cycles, then timeout
    no_ack = 1'b1;
    rq0 = req_cycles;
    run_bist(17'h00400, 17'd2, 2'd0, 8'h11, cyc);
    chk("to done_cycle", cyc, 256);
    chk("to req_cycles", req_cycles - rq0, 255);
    chk("to timed_out", timed_out, 1);
    chk("to fail", fail, 1);
    chk("to aborted", aborted, 0);
    chk("to req_low", bus.req, 0);
    no_ack = 1'b0;
    run_bist(17'h00010, 17'd4, 2'd1, 8'h00, cyc);
    chk("after_to done_cycle", cyc, 17);
    chk("after_to status", {fail, timed_out, aborted}, 0);

    // ignored start while busy, then abort coinciding with a mismatching read ack
    force_en = 1'b1; force_addr = 17'h00022; force_val = 8'h00;
    @(negedge clk);
    cfg_base = 17'h00020; cfg_len = 17'd4; cfg_mode = 2'd0; cfg_seed = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cfg_base = 17'h00055; cfg_len = 17'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab busy_kept", busy, 1);
    chk("ab no_done", done, 0);
    chk("ab addr_kept", bus.addr, 17'h00021);
    n = 0;
    while (!(bus.req && !bus.we && bus.addr == 17'h00022) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ab reached_read", n < 100, 1);
    chk("ab ack_present", bus.ack, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab req_low", bus.req, 0);
    chk("ab done", done, 1);
    chk("ab busy", busy, 0);
    chk("ab aborted", aborted, 1);
    chk("ab fail", fail, 1);
    chk("ab err_count", err_count, 0);
    chk("ab timed_out", timed_out, 0);

    // synchronous reset mid-run after a mismatch has been recorded
    force_addr = 17'h00010; force_val = 8'h00;
    @(negedge clk);
    cfg_base = 17'h00010; cfg_len = 17'd4; cfg_mode = 2'd0; cfg_seed = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("rst pre_fail", fail, 1);
    chk("rst pre_err", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst req", bus.req, 0);
    chk("rst busy_done", {busy, done}, 0);
    chk("rst status", {fail, timed_out, aborted}, 0);
    chk("rst err_count", err_count, 0);
    chk("rst fail_addr", fail_addr, 0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("rst stays_idle", nd, 0);
    force_en = 1'b0;

    // random-wait slave, long window, all four modes
    rand_wait = 1'b1;
    mon_en = 1'b1;
    for (int m = 0; m < 4; m++) begin
      rb = AW'($urandom_range(0, (1 << AW) - 1));
      rs = DW'($urandom_range(0, 255));
      ls = wlog.size();
      run_bist(rb, 17'd300, 2'(m), rs, cyc);
      chk($sformatf("rnd m%0d status", m), {fail, timed_out, aborted}, 0);
      chk($sformatf("rnd m%0d err_count", m), err_count, 0);
      chk($sformatf("rnd m%0d min_len", m), cyc >= 1201, 1);
      chk($sformatf("rnd m%0d writes", m), bad_writes(ls, rb, 300, 2'(m), rs), 0);
    end
    mon_en = 1'b0;
    chk("rnd bus_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
